dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYC, default 1, wait states per access (range 0-15).
REQ-003 SHALL have a single clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 address  input  32  byte address from the MEM stage.
REQ-007 data_write  input  32  store data, right-justified.
REQ-008 size  input  2  00 word, 01 halfword, 10 byte, 11 word.
REQ-009 mem_read  input  1  load request.
REQ-010 mem_write  input  1  store request.
REQ-011 data_mem  output  32  load data, right-justified, zero-extended.
REQ-012 stall  output  1  pipeline freeze; requester holds all inputs stable while high.
REQ-013 misaligned  output  1  one-cycle error pulse.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-015 Request = mem_read | mem_write; IDLE with request -> WAIT, or -> DONE when WAIT_CYC=0; counter loaded with WAIT_CYC-1.
REQ-016 WAIT: decrement counter; counter==0 -> DONE.
REQ-017 DONE -> IDLE unconditionally; a request present in the following IDLE cycle is a new access.
REQ-018 stall = request & (state != DONE), combinational; request in IDLE at cycle T0 gives stall high T0..T0+WAIT_CYC, low at T0+WAIT_CYC+1 (DONE).
REQ-019 Word index = address[ADDR_W+1:2]; higher address bits ignored (wrap modulo memory size).
REQ-020 Little-endian lanes: byte k = bits 8k+7:8k, selected by address[1:0].
REQ-021 Store: on the edge entering DONE, write the byte to lane address[1:0], the halfword to lanes address[1]*2+1:address[1]*2, or the full word; data taken from the low bits of data_write; other lanes unchanged.
REQ-022 Load: on the edge entering DONE, register the addressed lane(s) right-justified and zero-extended into data_mem; sign extension is the requester's job.
REQ-023 data_mem SHALL hold its value until the next load completes; stores do not change it.
REQ-024 Misaligned: halfword with address[0]=1, or word with address[1:0]!=0 -> no array write, data_mem loaded with 0 on loads, misaligned high in the DONE cycle only.
REQ-025 mem_read and mem_write both high SHALL be treated as a store; data_mem is loaded with 0.
REQ-026 Inputs SHALL be sampled on the edge entering DONE only; changes during a stall are a protocol violation and are not checked.

Reset
REQ-027 rst SHALL force state=IDLE, counter=0, data_mem=0, misaligned=0 immediately, regardless of the clock.
REQ-028 Reset mid-access SHALL abort the access with no array write; a request held after reset release starts a fresh access.
REQ-029 Array contents SHALL NOT be reset.

Structure
REQ-030 Package dmem_pkg SHALL hold SIZE_WORD/SIZE_HALF/SIZE_BYTE encodings and the FSM state encoding.
REQ-031 Sub-module dmem_array SHALL provide a synchronous RAM with four byte lanes, per-lane write enables, and a registered read; the FSM, lane steering, and checks stay in dmem_responder.

Verification
REQ-032 WAIT_CYC=1: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> stall high 2 cycles per access, data_mem=0xDEADBEEF in the load's DONE cycle.
REQ-033 After REQ-032: store byte 0x5A at 0x12, load word 0x10 -> 0xDE5ABEEF; load byte 0x13 -> 0x000000DE.
REQ-034 Store halfword at 0x11 -> misaligned pulses once, memory unchanged; load word at 0x02 -> data_mem=0, misaligned=1.
REQ-035 WAIT_CYC=0: back-to-back loads at 0x10 and 0x14 -> stall high exactly 1 cycle each; DONE and IDLE alternate.
REQ-036 Assert rst during WAIT of a store to 0x20 -> stall drops, data_mem=0, a later load at 0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and lane-steering helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_HALF: bad = off[0];
      SIZE_BYTE: bad = 1'b0;
      default:   bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      SIZE_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
      SIZE_BYTE: mask = 4'b0001 << off;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Replicating the narrow value across lanes lets the byte enables pick the target lane.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      SIZE_HALF: w = {2{data[15:0]}};
      SIZE_BYTE: w = {4{data[7:0]}};
      default:   w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_steer(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      SIZE_HALF: r = {16'h0000, sh[15:0]};
      SIZE_BYTE: r = {24'h000000, sh[7:0]};
      default:   r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the data memory.
interface dmem_responder_if;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [1:0]  size;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_mem;
  logic        stall;
  logic        misaligned;

  modport master (
    output address, data_write, size, mem_read, mem_write,
    input  data_mem, stall, misaligned
  );

  modport slave (
    input  address, data_write, size, mem_read, mem_write,
    output data_mem, stall, misaligned
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with four byte lanes and a registered, enabled read port.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  // Read register only updates on re so the top can derive its held load data from it.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem_q[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM, byte-lane steering and alignment checks around dmem_array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic        zero_q, zero_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  rsize_q, rsize_d;

  logic        req, is_load, is_store, bad, enter_done;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;
  logic        unused_addr_hi;

  assign req      = bus.mem_read | bus.mem_write;
  assign is_store = bus.mem_write;
  assign is_load  = bus.mem_read & ~bus.mem_write;
  assign bad      = is_misaligned(bus.size, bus.address[1:0]);
  assign unused_addr_hi = ^bus.address[31:ADDR_W+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = (WAIT_CYC == 0) ? ST_DONE : ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_comb begin
    mis_d   = enter_done & bad;
    zero_d  = zero_q;
    off_d   = off_q;
    rsize_d = rsize_q;
    if (enter_done && is_load) begin
      zero_d  = bad;
      off_d   = bus.address[1:0];
      rsize_d = bus.size;
    end else if (enter_done && bus.mem_read && bus.mem_write) begin
      zero_d  = 1'b1;
    end
  end

  assign we = (enter_done && is_store && !bad) ? lane_mask(bus.size, bus.address[1:0]) : 4'b0000;
  assign re = enter_done & is_load & ~bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mis_q   <= 1'b0;
      zero_q  <= 1'b1;
      off_q   <= 2'b00;
      rsize_q <= SIZE_WORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      zero_q  <= zero_d;
      off_q   <= off_d;
      rsize_q <= rsize_d;
    end
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .addr  (bus.address[ADDR_W+1:2]),
    .we    (we),
    .wdata (store_lanes(bus.size, bus.data_write)),
    .re    (re),
    .rdata (rdata)
  );

  // Stall is released during reset so an aborted access does not freeze the pipeline.
  assign bus.stall      = req & (state_q != ST_DONE) & ~rst;
  assign bus.misaligned = mis_q;
  assign bus.data_mem   = zero_q ? 32'h0 : load_steer(rsize_q, off_q, rdata);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: WAIT_CYC=1 instance for access/lane/misalign/reset cases, WAIT_CYC=0 for back-to-back.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if b0();
  dmem_responder_if b1();

  dmem_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  dmem_responder #(.ADDR_W(10), .WAIT_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int errors = 0;
  int checks = 0;

  task automatic drive(input bit w0, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input bit rd, input bit wr);
    if (w0) begin
      b0.address = addr; b0.data_write = wd; b0.size = sz; b0.mem_read = rd; b0.mem_write = wr;
    end else begin
      b1.address = addr; b1.data_write = wd; b1.size = sz; b1.mem_read = rd; b1.mem_write = wr;
    end
  endtask

  // Issues one access, counts stall cycles, returns DONE-cycle outputs; request dropped afterwards.
  task automatic access(input bit w0, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input bit rd, input bit wr,
                        output int stalls, output logic [31:0] dout, output logic mis);
    logic st;
    @(posedge clk); #1;
    drive(w0, addr, wd, sz, rd, wr);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      st = w0 ? b0.stall : b1.stall;
      if (!st) break;
      stalls++;
      @(posedge clk); #1;
    end
    dout = w0 ? b0.data_mem : b1.data_mem;
    mis  = w0 ? b0.misaligned : b1.misaligned;
    @(posedge clk); #1;
    drive(w0, 32'h0, 32'h0, SIZE_WORD, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (b1.data_mem !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", b1.data_mem); end
    checks++; if (b1.misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", b1.misaligned); end
    checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", b0.stall); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_word_rw();
    int s; logic [31:0] d; logic m;
    access(1'b0, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, 1'b1, s, d, m);
    checks++; if (s !== 2) begin errors++; $display("FAIL store_stall: got %0d want 2", s); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL store_keeps_data: got %h want 00000000", d); end
    access(1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    checks++; if (s !== 2) begin errors++; $display("FAIL load_stall: got %0d want 2", s); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word: got %h want deadbeef", d); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL load_word_mis: got %b want 0", m); end
  endtask

  task automatic test_byte_lanes();
    int s; logic [31:0] d; logic m;
    access(1'b0, 32'h12, 32'hFFFFFF5A, SIZE_BYTE, 1'b0, 1'b1, s, d, m);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL store_holds_data: got %h want deadbeef", d); end
    access(1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    checks++; if (d !== 32'hDE5ABEEF) begin errors++; $display("FAIL byte_merge: got %h want de5abeef", d); end
    access(1'b0, 32'h13, 32'h0, SIZE_BYTE, 1'b1, 1'b0, s, d, m);
    checks++; if (d !== 32'h000000DE) begin errors++; $display("FAIL load_byte3: got %h want 000000de", d); end
    access(1'b0, 32'h12, 32'h0, SIZE_HALF, 1'b1, 1'b0, s, d, m);
    checks++; if (d !== 32'h0000DE5A) begin errors++; $display("FAIL load_half_hi: got %h want 0000de5a", d); end
  endtask

  task automatic test_misaligned();
    int s; logic [31:0] d; logic m;
    access(1'b0, 32'h11, 32'h00001234, SIZE_HALF, 1'b0, 1'b1, s, d, m);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_half_pulse: got %b want 1", m); end
    #3;
    checks++; if (b1.misaligned !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b want 0", b1.misaligned); end
    access(1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    checks++; if (d !== 32'hDE5ABEEF) begin errors++; $display("FAIL mis_no_write: got %h want de5abeef", d); end
    access(1'b0, 32'h02, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mis_load_zero: got %h want 00000000", d); end
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_load_flag: got %b want 1", m); end
  endtask

  task automatic test_rw_both_and_wrap();
    int s; logic [31:0] d; logic m;
    access(1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    access(1'b0, 32'h30, 32'h0BADCAFE, SIZE_WORD, 1'b1, 1'b1, s, d, m);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL both_zero: got %h want 00000000", d); end
    access(1'b0, 32'h30, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    checks++; if (d !== 32'h0BADCAFE) begin errors++; $display("FAIL both_is_store: got %h want 0badcafe", d); end
    access(1'b0, 32'h1010, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    checks++; if (d !== 32'hDE5ABEEF) begin errors++; $display("FAIL addr_wrap: got %h want de5abeef", d); end
  endtask

  task automatic test_back_to_back();
    int s; logic [31:0] d; logic m;
    access(1'b1, 32'h10, 32'h11111111, SIZE_WORD, 1'b0, 1'b1, s, d, m);
    checks++; if (s !== 1) begin errors++; $display("FAIL w0_store_stall: got %0d want 1", s); end
    access(1'b1, 32'h14, 32'h22222222, SIZE_WORD, 1'b0, 1'b1, s, d, m);
    @(posedge clk); #1;
    drive(1'b1, 32'h10, 32'h0, SIZE_WORD, 1'b1, 1'b0);
    #3;
    checks++; if (b0.stall !== 1'b1) begin errors++; $display("FAIL b2b_c0_stall: got %b want 1", b0.stall); end
    @(posedge clk); #4;
    checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL b2b_c1_stall: got %b want 0", b0.stall); end
    checks++; if (b0.data_mem !== 32'h11111111) begin errors++; $display("FAIL b2b_c1_data: got %h want 11111111", b0.data_mem); end
    @(posedge clk); #1;
    b0.address = 32'h14;
    #3;
    checks++; if (b0.stall !== 1'b1) begin errors++; $display("FAIL b2b_c2_stall: got %b want 1", b0.stall); end
    @(posedge clk); #4;
    checks++; if (b0.stall !== 1'b0) begin errors++; $display("FAIL b2b_c3_stall: got %b want 0", b0.stall); end
    checks++; if (b0.data_mem !== 32'h22222222) begin errors++; $display("FAIL b2b_c3_data: got %h want 22222222", b0.data_mem); end
    @(posedge clk); #1;
    drive(1'b1, 32'h0, 32'h0, SIZE_WORD, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    int s; logic [31:0] d; logic m;
    access(1'b0, 32'h20, 32'hCAFEF00D, SIZE_WORD, 1'b0, 1'b1, s, d, m);
    access(1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    @(posedge clk); #1;
    drive(1'b0, 32'h20, 32'h12345678, SIZE_WORD, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL rst_stall_drop: got %b want 0", b1.stall); end
    checks++; if (b1.data_mem !== 32'h0) begin errors++; $display("FAIL rst_data_clear: got %h want 00000000", b1.data_mem); end
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, SIZE_WORD, 1'b0, 1'b0);
    rst = 1'b0;
    access(1'b0, 32'h20, 32'h0, SIZE_WORD, 1'b1, 1'b0, s, d, m);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_no_write: got %h want cafef00d", d); end
    checks++; if (s !== 2) begin errors++; $display("FAIL rst_fresh_stall: got %0d want 2", s); end
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, SIZE_WORD, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 32'h0, SIZE_WORD, 1'b0, 1'b0);
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_misaligned();
    test_rw_both_and_wrap();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
